// File: rtl/alu_result_deserializer.sv
// Serial-to-parallel capture of ALU result frames: NUM_WORDS words of WORD_W bits, MSB first.
// Define DESER_PARITY_CHECK_EN to enable per-word even-parity checking and parity-gated frame counting.
module alu_result_deserializer #(
  parameter int NUM_WORDS = 3,
  parameter int WORD_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dout,
  input  logic                   dout_valid,
  output logic [8*NUM_WORDS-1:0] res_data,
  output logic [NUM_WORDS-1:0]   res_ctl,
  output logic [NUM_WORDS-1:0]   res_par_err,
  output logic                   res_valid,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  localparam int TOTAL = NUM_WORDS * WORD_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t                 state, state_nx;
  logic [TOTAL-1:0]       sr, sr_nx;
  logic [CNT_W-1:0]       cnt;
  logic                   dv_q;
  logic                   ovr_done;
  logic                   take, done, trunc, ovr;
  logic [8*NUM_WORDS-1:0] data_nx;
  logic [NUM_WORDS-1:0]   ctl_nx, par_nx;
  logic                   good;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    done     = 1'b0;
    trunc    = 1'b0;
    ovr      = 1'b0;
    case (state)
      // dv_q is preset by reset so a qualifier held across reset cannot start a frame
      IDLE: if (dout_valid && !dv_q) begin
        take     = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: if (dout_valid) begin
        take = 1'b1;
        if (cnt == CNT_W'(TOTAL - 1)) begin
          done     = 1'b1;
          state_nx = TAIL;
        end
      end else begin
        trunc    = 1'b1;
        state_nx = IDLE;
      end
      TAIL: if (!dout_valid) state_nx = IDLE;
            else if (!ovr_done) ovr = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  // Decode straight from the next shift value so results land one cycle after the last bit
  always_comb begin
    sr_nx   = {sr[TOTAL-2:0], dout};
    data_nx = '0;
    ctl_nx  = '0;
    par_nx  = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      data_nx[8*k +: 8] = sr_nx[(NUM_WORDS-1-k)*WORD_W + 1 +: 8];
      ctl_nx[k]         = sr_nx[(NUM_WORDS-1-k)*WORD_W + WORD_W - 1];
`ifdef DESER_PARITY_CHECK_EN
      par_nx[k]         = ^sr_nx[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
`endif
    end
    good = (par_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dv_q        <= 1'b1;
      ovr_done    <= 1'b0;
      sr          <= '0;
      res_data    <= '0;
      res_ctl     <= '0;
      res_par_err <= '0;
      res_valid   <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state     <= state_nx;
      dv_q      <= dout_valid;
      res_valid <= done;
      frame_err <= trunc;
      overrun   <= ovr;
      if (take) begin
        sr  <= sr_nx;
        cnt <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
      end
      if (trunc) cnt <= '0;
      if (ovr) ovr_done <= 1'b1;
      if (done) begin
        cnt         <= '0;
        ovr_done    <= 1'b0;
        res_data    <= data_nx;
        res_ctl     <= ctl_nx;
        res_par_err <= par_nx;
        if (good && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule
